mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, memory word and address width.
REQ-002 SHALL have parameter LATENCY, default 1, legal 1..4, cycles from mem_en to valid mem_rdata.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction-fetch request, held until i_gnt.
- i_addr  in  DATA_WIDTH  fetch address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid, one-cycle pulse.
- i_rdata  out  DATA_WIDTH  fetch data.
- d_req  in  1  data request, held until d_gnt.
- d_we  in  1  data write when 1, read when 0.
- d_addr  in  DATA_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data / write completion, one-cycle pulse.
- d_rdata  out  DATA_WIDTH  data read data.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid LATENCY cycles after mem_en.

Function
REQ-004 SHALL implement FSM with states IDLE, WAIT, RESP.
REQ-005 SHALL leave IDLE only when i_req or d_req is 1; at most one requester is granted per access.
REQ-006 SHALL drive i_gnt/d_gnt combinationally in IDLE only; mem_en, mem_we, mem_addr, mem_wdata SHALL reflect the granted requester in that same cycle (mem_we = d_we for data, 0 for fetch).
REQ-007 SHALL arbitrate round-robin: on simultaneous requests grant the requester not granted last; a lone requester is always granted.
REQ-008 SHALL record the granted requester (owner) and whether the access is a write at the grant cycle.
REQ-009 SHALL go IDLE->WAIT on grant when LATENCY>1, IDLE->RESP when LATENCY=1; WAIT lasts LATENCY-1 cycles, counted by a down-counter, then ->RESP.
REQ-010 SHALL, in RESP, pulse the owner's rvalid for exactly one cycle with rdata = mem_rdata; on write completion d_rdata SHALL be 0.
REQ-011 SHALL go RESP->IDLE unconditionally; grant-to-rvalid latency = LATENCY cycles, access period = LATENCY+1 cycles.
REQ-012 SHALL keep i_rdata/d_rdata at 0 whenever the matching rvalid is 0.
REQ-013 SHALL keep mem_en, i_gnt and d_gnt at 0 in WAIT and RESP; requests arriving then stay pending.
REQ-014 SHALL ignore request, address and data changes outside the grant cycle.

Reset
REQ-015 SHALL, while rst=0, force state IDLE, counter 0, owner fetch, last-granted = data (fetch wins first conflict).
REQ-016 SHALL hold all outputs at 0 during reset.
REQ-017 SHALL abandon any in-flight access on reset; no rvalid SHALL be produced for it after release.

Structure
REQ-018 SHALL take FSM state encoding and requester-ID constants (FETCH=0, DATA=1) from shared package hyper_pkg.
REQ-019 SHALL put the two-way round-robin priority logic in sub-module rr_arbiter2 (req[1:0], update, gnt[1:0]).

Verification
REQ-020 Lone fetch: LATENCY=1, i_req=1, i_addr=0x0003, memory[3]=0x1001 -> i_gnt cycle T, i_rvalid=1 with i_rdata=0x1001 at T+1, IDLE at T+2.
REQ-021 Conflict after reset: i_req=d_req=1 held -> grants alternate fetch, data, fetch, data; each grant LATENCY+1 cycles apart.
REQ-022 Write then read: d_we=1, d_addr=0x0005, d_wdata=0xBEEF, then read 0x0005 -> mem_we=1 one cycle, d_rvalid with d_rdata=0; read returns 0xBEEF.
REQ-023 LATENCY=3: d_req read at T -> mem_en only at T, d_rvalid only at T+3; i_req raised at T+1 -> i_gnt at T+4.
REQ-024 Reset mid-access: LATENCY=4, grant at T, rst=0 at T+2 for one cycle -> no rvalid ever for that access, state IDLE, outputs 0.
REQ-025 Idle: no requests for 20 cycles -> mem_en, gnts, rvalids all 0.

Source files
------------

// File: rtl/hyper_pkg.sv
// Shared constants for the memory arbiter: FSM encoding, requester IDs, access record.
// Purely declarative; no timing or flow-control behaviour lives here.
package hyper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic REQ_FETCH = 1'b0;
   localparam logic REQ_DATA  = 1'b1;

   typedef struct packed {
      logic owner;
      logic we;
   } acc_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: combinational grant, remembers the last winner on update.
// No backpressure; a lone requester always wins, ties go to the one not granted last.
module rr_arbiter2
   import hyper_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt    = req;
      last_d = last_q;
      if (req == 2'b11) begin
         gnt = (last_q == REQ_DATA) ? 2'b01 : 2'b10;
      end
      if (update && (gnt != 2'b00)) begin
         last_d = gnt[REQ_DATA];
      end
   end

   // Reset to DATA so fetch wins the first conflict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= REQ_DATA;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data requesters; one access in flight.
// Grant-to-rvalid = LATENCY cycles, period LATENCY+1; requests held while busy.
module mem_arbiter
   import hyper_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [DATA_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DATA_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int CW = 2;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   acc_t          acc_q, acc_d;
   logic [1:0]    arb_req;
   logic [1:0]    arb_gnt;
   logic          grant;

   // Requests are only visible to the arbiter while idle, so busy-time requests stay pending.
   assign arb_req = (state_q == ST_IDLE) ? {d_req, i_req} : 2'b00;
   assign grant   = |arb_gnt;

   rr_arbiter2 u_rr (
      .clk    (clk),
      .rst_n  (rst),
      .req    (arb_req),
      .update (grant),
      .gnt    (arb_gnt)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               acc_d.owner = arb_gnt[REQ_DATA];
               acc_d.we    = arb_gnt[REQ_DATA] & d_we;
               if (LATENCY > 1) begin
                  state_d = ST_WAIT;
                  cnt_d   = CW'(LATENCY - 2);
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are forced low while reset is asserted, including the combinational grant path.
   always_comb begin
      i_gnt     = 1'b0;
      d_gnt     = 1'b0;
      i_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      i_rdata   = '0;
      d_rdata   = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst) begin
         if ((state_q == ST_IDLE) && grant) begin
            i_gnt  = arb_gnt[REQ_FETCH];
            d_gnt  = arb_gnt[REQ_DATA];
            mem_en = 1'b1;
            if (arb_gnt[REQ_DATA]) begin
               mem_we    = d_we;
               mem_addr  = d_addr;
               mem_wdata = d_wdata;
            end else begin
               mem_addr  = i_addr;
            end
         end
         if (state_q == ST_RESP) begin
            if (acc_q.owner == REQ_DATA) begin
               d_rvalid = 1'b1;
               d_rdata  = acc_q.we ? '0 : mem_rdata;
            end else begin
               i_rvalid = 1'b1;
               i_rdata  = mem_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '{owner: REQ_FETCH, we: 1'b0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LATENCY 1, 3, 4), each with a memory and a
// transaction-level model checked every cycle, plus directed literal checks.
module tb_mem_arbiter;

   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          rst       [3];
   logic          i_req     [3];
   logic [DW-1:0] i_addr    [3];
   logic          d_req     [3];
   logic          d_we      [3];
   logic [DW-1:0] d_addr    [3];
   logic [DW-1:0] d_wdata   [3];
   logic          i_gnt     [3];
   logic          i_rvalid  [3];
   logic [DW-1:0] i_rdata   [3];
   logic          d_gnt     [3];
   logic          d_rvalid  [3];
   logic [DW-1:0] d_rdata   [3];
   logic          mem_en    [3];
   logic          mem_we    [3];
   logic [DW-1:0] mem_addr  [3];
   logic [DW-1:0] mem_wdata [3];
   logic [DW-1:0] mem_rdata [3];

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s lane%0d cyc=%0d actual=0x%0h required=0x%0h", nm, lane, cyc, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : lane
      localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;

      mem_arbiter #(.DATA_WIDTH(DW), .LATENCY(L)) u_dut (
         .clk       (clk),
         .rst       (rst[g]),
         .i_req     (i_req[g]),
         .i_addr    (i_addr[g]),
         .i_gnt     (i_gnt[g]),
         .i_rvalid  (i_rvalid[g]),
         .i_rdata   (i_rdata[g]),
         .d_req     (d_req[g]),
         .d_we      (d_we[g]),
         .d_addr    (d_addr[g]),
         .d_wdata   (d_wdata[g]),
         .d_gnt     (d_gnt[g]),
         .d_rvalid  (d_rvalid[g]),
         .d_rdata   (d_rdata[g]),
         .mem_en    (mem_en[g]),
         .mem_we    (mem_we[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g])
      );

      // Memory: reads captured at mem_en, presented exactly L cycles later, junk otherwise.
      logic [DW-1:0] mem  [256];
      logic [DW-1:0] rmem [256];
      logic [DW-1:0] rd_d [16];
      logic          rd_v [16];

      initial begin
         for (int i = 0; i < 256; i++) begin
            mem[i]  = 16'(i * 257) ^ 16'h5A5A;
            rmem[i] = 16'(i * 257) ^ 16'h5A5A;
         end
         mem[3]  = 16'h1001;
         rmem[3] = 16'h1001;
         for (int i = 0; i < 16; i++) rd_v[i] = 1'b0;
         mem_rdata[g] = 16'hDEAD;
      end

      always @(negedge clk) begin
         if (mem_en[g]) begin
            if (mem_we[g]) begin
               mem[mem_addr[g][7:0]] = mem_wdata[g];
            end else begin
               rd_d[(cyc + L) % 16] = mem[mem_addr[g][7:0]];
               rd_v[(cyc + L) % 16] = 1'b1;
            end
         end
      end

      always @(posedge clk) begin
         #1;
         if (rd_v[cyc % 16]) begin
            mem_rdata[g]    = rd_d[cyc % 16];
            rd_v[cyc % 16]  = 1'b0;
         end else begin
            mem_rdata[g] = 16'hDEAD;
         end
      end

      // Model: busy counts cycles until the arbiter can grant again; one response is owed.
      int            busy = 0;
      bit            last = 1'b1;
      bit            rp   = 1'b0;
      int            rc   = 0;
      bit            ro   = 1'b0;
      bit            rw   = 1'b0;
      logic [DW-1:0] rdat = '0;

      always @(negedge clk) begin : model
         logic          e_ig, e_dg, e_iv, e_dv, e_en, e_we, pick;
         logic [DW-1:0] e_id, e_dd, e_ad, e_wd;
         e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_en = 0; e_we = 0; pick = 0;
         e_id = '0; e_dd = '0; e_ad = '0; e_wd = '0;
         if (!rst[g]) begin
            busy = 0;
            last = 1'b1;
            rp   = 1'b0;
         end else begin
            if (rp && cyc == rc) begin
               if (ro) begin
                  e_dv = 1'b1;
                  e_dd = rw ? '0 : rdat;
               end else begin
                  e_iv = 1'b1;
                  e_id = rdat;
               end
               rp = 1'b0;
            end
            if (busy == 0 && (i_req[g] || d_req[g])) begin
               pick = (i_req[g] && d_req[g]) ? !last : d_req[g];
               e_en = 1'b1;
               if (pick) begin
                  e_dg = 1'b1;
                  e_we = d_we[g];
                  e_ad = d_addr[g];
                  e_wd = d_wdata[g];
               end else begin
                  e_ig = 1'b1;
                  e_ad = i_addr[g];
               end
               rw   = e_we;
               rdat = rw ? '0 : rmem[e_ad[7:0]];
               if (rw) rmem[e_ad[7:0]] = e_wd;
               ro   = pick;
               rp   = 1'b1;
               rc   = cyc + L;
               busy = L;
               last = pick;
            end else if (busy > 0) begin
               busy--;
            end
         end
         chk("m_i_gnt",     g, 32'(i_gnt[g]),     32'(e_ig));
         chk("m_d_gnt",     g, 32'(d_gnt[g]),     32'(e_dg));
         chk("m_i_rvalid",  g, 32'(i_rvalid[g]),  32'(e_iv));
         chk("m_i_rdata",   g, 32'(i_rdata[g]),   32'(e_id));
         chk("m_d_rvalid",  g, 32'(d_rvalid[g]),  32'(e_dv));
         chk("m_d_rdata",   g, 32'(d_rdata[g]),   32'(e_dd));
         chk("m_mem_en",    g, 32'(mem_en[g]),    32'(e_en));
         chk("m_mem_we",    g, 32'(mem_we[g]),    32'(e_we));
         chk("m_mem_addr",  g, 32'(mem_addr[g]),  32'(e_ad));
         chk("m_mem_wdata", g, 32'(mem_wdata[g]), 32'(e_wd));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b0; i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0;
         d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      end
      // Both requesters held through reset: outputs must stay low.
      i_req[0] = 1'b1; d_req[0] = 1'b1; i_addr[0] = 16'h0003; d_addr[0] = 16'h0003;
      smp();
      chk("rst_outs", 0, 32'({i_gnt[0], d_gnt[0], mem_en[0], mem_we[0], i_rvalid[0], d_rvalid[0]}), 32'h0);
      chk("rst_addr", 0, 32'(mem_addr[0]), 32'h0);

      // Conflict from reset release: fetch, data, fetch, data, two cycles apart.
      step();
      for (int k = 0; k < 3; k++) rst[k] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) step();
         smp();
         chk("rr_i_gnt", 0, 32'(i_gnt[0]), 32'(c % 4 == 0));
         chk("rr_d_gnt", 0, 32'(d_gnt[0]), 32'(c % 4 == 2));
         if (c % 4 == 1) chk("rr_i_resp", 0, 32'({i_rvalid[0], i_rdata[0]}), 32'h1_1001);
         if (c % 4 == 3) chk("rr_d_resp", 0, 32'({d_rvalid[0], d_rdata[0]}), 32'h1_1001);
      end

      step();
      i_req[0] = 1'b0; d_req[0] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) step();
         smp();
         chk("idle", 0, 32'({mem_en[0], i_gnt[0], d_gnt[0], i_rvalid[0], d_rvalid[0]}), 32'h0);
      end

      // Lone fetch, then write and read-back on the data port.
      step();
      i_req[0] = 1'b1; i_addr[0] = 16'h0003;
      smp();
      chk("lf_gnt",  0, 32'({i_gnt[0], d_gnt[0], mem_en[0], mem_we[0]}), 32'b1010);
      chk("lf_addr", 0, 32'(mem_addr[0]), 32'h0003);
      step();
      i_req[0] = 1'b0; i_addr[0] = 16'h7777;
      smp();
      chk("lf_resp", 0, 32'({i_gnt[0], i_rvalid[0], i_rdata[0]}), 32'h1_1001);
      step();
      d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0005; d_wdata[0] = 16'hBEEF;
      smp();
      chk("wr_gnt", 0, 32'({i_rvalid[0], d_gnt[0], mem_en[0], mem_we[0]}), 32'b0111);
      chk("wr_bus", 0, {mem_addr[0], mem_wdata[0]}, 32'h0005_BEEF);
      step();
      d_req[0] = 1'b0; d_wdata[0] = 16'h1234; d_addr[0] = 16'h0009;
      smp();
      chk("wr_done", 0, 32'({d_rvalid[0], d_rdata[0], mem_en[0]}), 32'h2_0000);
      step();
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0005;
      smp();
      chk("rd_gnt", 0, 32'({d_gnt[0], mem_en[0], mem_we[0]}), 32'b110);
      step();
      d_req[0] = 1'b0;
      smp();
      chk("rd_data", 0, 32'({d_rvalid[0], d_rdata[0]}), 32'h1_BEEF);

      // LATENCY=3: data read at T, fetch raised at T+1 granted at T+4.
      step();
      d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h0010;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) step();
         if (c == 1) begin
            d_req[1] = 1'b0; i_req[1] = 1'b1; i_addr[1] = 16'h0020;
         end
         if (c == 5) i_req[1] = 1'b0;
         smp();
         chk("l3_en",   1, 32'(mem_en[1]), 32'(c == 0 || c == 4));
         chk("l3_resp", 1, 32'({d_rvalid[1], d_rdata[1]}), (c == 3) ? 32'h1_4A4A : 32'h0);
         chk("l3_igp",  1, 32'(i_gnt[1]), 32'(c == 4));
      end

      // LATENCY=4: reset pulse two cycles after grant abandons the access.
      step();
      i_req[2] = 1'b1; i_addr[2] = 16'h0007;
      smp();
      chk("l4_gnt", 2, 32'(i_gnt[2]), 32'h1);
      step();
      i_req[2] = 1'b0;
      step();
      rst[2] = 1'b0;
      smp();
      chk("l4_rst_outs", 2, 32'({i_gnt[2], d_gnt[2], mem_en[2], i_rvalid[2], d_rvalid[2], mem_addr[2]}), 32'h0);
      step();
      rst[2] = 1'b1;
      smp();
      chk("l4_no_rv3", 2, 32'({i_rvalid[2], d_rvalid[2]}), 32'h0);
      step();
      d_req[2] = 1'b1; d_addr[2] = 16'h0030;
      smp();
      chk("l4_idle_gnt", 2, 32'({d_gnt[2], i_rvalid[2]}), 32'b10);
      step();
      d_req[2] = 1'b0;
      smp();
      chk("l4_no_rv5", 2, 32'(i_rvalid[2]), 32'h0);
      repeat (8) step();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
